// File: rtl/crc_sched_pkg.sv
// Shared types and constants for the two-requester CRC32 block scheduler.
package crc_sched_pkg;

    localparam int unsigned NUM_REQ         = 2;
    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
    localparam int unsigned CNT_W           = $clog2(WORDS_PER_BLOCK);

    localparam logic [WORD_W-1:0] DEF_CRC_POLY  = 32'h04C11DB7;
    localparam logic [WORD_W-1:0] DEF_CRC_INIT  = 32'hFFFFFFFF;
    localparam logic [WORD_W-1:0] DEF_FINAL_XOR = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMPUTE = 2'd2,
        RESULT  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] crc;
        logic              id;
        logic              err;
    } crc_result_t;

endpackage

// File: rtl/lfsr.sv
// Combinational Galois LFSR that folds DATA_WIDTH data bits into the state in one step.
module lfsr #(
    parameter int unsigned               LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0]     LFSR_POLY  = LFSR_WIDTH'(32'h04C11DB7),
    parameter bit                        REVERSE    = 1'b1,
    parameter int unsigned               DATA_WIDTH = 256
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [LFSR_WIDTH-1:0] state_out
);

    function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
        logic [LFSR_WIDTH-1:0] r;
        for (int unsigned i = 0; i < LFSR_WIDTH; i++) begin
            r[i] = v[LFSR_WIDTH-1-i];
        end
        return r;
    endfunction

    // Reflected engines shift right, so they use the bit-reversed polynomial.
    localparam logic [LFSR_WIDTH-1:0] POLY_EFF = REVERSE ? reflect(LFSR_POLY) : LFSR_POLY;

    logic [LFSR_WIDTH-1:0] s;
    logic                  fb;

    always_comb begin
        s  = state_in;
        fb = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (REVERSE) begin
                fb = s[0] ^ data_in[i];
                s  = s >> 1;
            end else begin
                fb = s[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
                s  = s << 1;
            end
            if (fb) begin
                s = s ^ POLY_EFF;
            end
        end
        state_out = s;
    end

endmodule

// File: rtl/crc_block_scheduler.sv
// Round-robin frame arbiter that packs 32-bit words into 256-bit blocks and chains
// the CRC32 state across blocks, reporting one tagged result per frame.
module crc_block_scheduler
    import crc_sched_pkg::*;
#(
    parameter logic [WORD_W-1:0] CRC_POLY  = DEF_CRC_POLY,
    parameter logic [WORD_W-1:0] CRC_INIT  = DEF_CRC_INIT,
    parameter logic [WORD_W-1:0] FINAL_XOR = DEF_FINAL_XOR
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ*WORD_W-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ-1:0]          req_last_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [WORD_W-1:0]           crc_o,
    output logic                        crc_id_o,
    output logic                        crc_err_o,
    output logic                        crc_valid_o,
    input  logic                        crc_ready_i
);

    sched_state_e          fsm_q, fsm_d;
    logic                  rr_ptr_q;
    logic                  grant_q;
    logic [CNT_W-1:0]      word_cnt_q;
    logic [BLOCK_W-1:0]    block_q;
    logic [WORD_W-1:0]     crc_state_q;
    logic                  last_q;
    logic                  err_q;
    crc_result_t           result_q;
    logic [WORD_W-1:0]     lfsr_out;
    logic [NUM_REQ-1:0]    ready_d;

    logic                  grant_c;
    logic                  next_grant_c;
    logic [WORD_W-1:0]     word_c;
    logic                  last_c;
    logic                  accept_c;
    logic                  blk_done_c;

    lfsr #(
        .LFSR_WIDTH (WORD_W),
        .LFSR_POLY  (CRC_POLY),
        .REVERSE    (1'b1),
        .DATA_WIDTH (BLOCK_W)
    ) u_lfsr (
        .data_in   (block_q),
        .state_in  (crc_state_q),
        .state_out (lfsr_out)
    );

    // A lone requester wins outright; on contention the round-robin pointer decides.
    always_comb begin
        grant_c = rr_ptr_q;
        unique case (req_valid_i)
            2'b01:   grant_c = 1'b0;
            2'b10:   grant_c = 1'b1;
            default: grant_c = rr_ptr_q;
        endcase
    end

    assign word_c     = grant_q ? req_data_i[2*WORD_W-1:WORD_W] : req_data_i[WORD_W-1:0];
    assign last_c     = req_last_i[grant_q];
    assign accept_c   = (fsm_q == COLLECT) && req_valid_i[grant_q] && req_ready_o[grant_q];
    assign blk_done_c = (word_cnt_q == CNT_W'(WORDS_PER_BLOCK - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    if (|req_valid_i) fsm_d = COLLECT;
            COLLECT: begin
                if (accept_c) begin
                    if (blk_done_c)  fsm_d = COMPUTE;
                    else if (last_c) fsm_d = RESULT;
                end
            end
            COMPUTE: fsm_d = last_q ? RESULT : COLLECT;
            RESULT:  if (crc_valid_o && crc_ready_i) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Ready is registered: it is high exactly while the next state is COLLECT.
    always_comb begin
        next_grant_c = (fsm_q == IDLE) ? grant_c : grant_q;
        ready_d      = '0;
        if (fsm_d == COLLECT) begin
            ready_d = NUM_REQ'(1) << next_grant_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= 1'b0;
            grant_q     <= 1'b0;
            word_cnt_q  <= '0;
            block_q     <= '0;
            crc_state_q <= CRC_INIT;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            req_ready_o <= '0;
            result_q    <= '0;
            crc_valid_o <= 1'b0;
        end else begin
            req_ready_o <= ready_d;
            unique case (fsm_q)
                IDLE: begin
                    if (|req_valid_i) begin
                        grant_q     <= grant_c;
                        rr_ptr_q    <= ~grant_c;
                        crc_state_q <= CRC_INIT;
                        word_cnt_q  <= '0;
                    end
                end
                COLLECT: begin
                    if (accept_c) begin
                        block_q[int'(word_cnt_q)*WORD_W +: WORD_W] <= word_c;
                        word_cnt_q <= word_cnt_q + CNT_W'(1);
                        if (blk_done_c)  last_q <= last_c;
                        else if (last_c) err_q  <= 1'b1;
                    end
                end
                COMPUTE: crc_state_q <= lfsr_out;
                RESULT: begin
                    // First RESULT cycle captures the result; it then holds until taken.
                    if (!crc_valid_o) begin
                        result_q.crc <= err_q ? '0 : (crc_state_q ^ FINAL_XOR);
                        result_q.id  <= grant_q;
                        result_q.err <= err_q;
                        crc_valid_o  <= 1'b1;
                    end else if (crc_ready_i) begin
                        crc_valid_o  <= 1'b0;
                        err_q        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign crc_o     = result_q.crc;
    assign crc_id_o  = result_q.id;
    assign crc_err_o = result_q.err;

endmodule

// File: tb/tb_crc_block_scheduler.sv
// Directed bench for crc_block_scheduler with a byte-wise reflected CRC-32 reference.
module tb_crc_block_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req_data;
    logic [1:0]  req_valid;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [31:0] crc;
    logic        crc_id;
    logic        crc_err;
    logic        crc_valid;
    logic        crc_ready;

    always #5 clk = ~clk;

    crc_block_scheduler dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .crc_o       (crc),
        .crc_id_o    (crc_id),
        .crc_err_o   (crc_err),
        .crc_valid_o (crc_valid),
        .crc_ready_i (crc_ready)
    );

    typedef struct { logic [31:0] d; logic last; } word_t;
    typedef struct { int cyc; int r; logic [31:0] d; } acc_t;
    typedef struct { int cyc; logic [31:0] crc; logic id; logic err; } res_t;
    typedef struct { int r; int n; logic [31:0] base; logic exp_err; } vec_t;

    word_t q0[$];
    word_t q1[$];
    acc_t  acc_log[$];
    res_t  res_log[$];
    int    rise_log[$];
    int    cyc = 0;
    logic  prev_valid = 1'b0;
    int    total = 0;
    int    bad = 0;
    vec_t  vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Standard byte-at-a-time reflected CRC-32 (0xEDB88320), little-endian byte order per word.
    function automatic logic [31:0] model_crc(input logic [31:0] base, input int n);
        logic [31:0] c;
        logic [31:0] w;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            w = base + 32'(i);
            for (int b = 0; b < 4; b++) begin
                c = c ^ {24'h0, w[8*b +: 8]};
                for (int k = 0; k < 8; k++) begin
                    c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
                end
            end
        end
        return ~c;
    endfunction

    task automatic drive();
        req_valid = 2'b00;
        req_last  = 2'b00;
        req_data  = 64'h0;
        if (q0.size() > 0) begin
            req_valid[0]    = 1'b1;
            req_data[31:0]  = q0[0].d;
            req_last[0]     = q0[0].last;
        end
        if (q1.size() > 0) begin
            req_valid[1]    = 1'b1;
            req_data[63:32] = q1[0].d;
            req_last[1]     = q1[0].last;
        end
    endtask

    task automatic push_frame(input int r, input int n, input logic [31:0] base);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.d    = base + 32'(i);
            w.last = (i == n - 1);
            if (r == 0) q0.push_back(w);
            else        q1.push_back(w);
        end
    endtask

    // One clock: observe handshakes at the falling edge, update stimulus just after the rising edge.
    // cyc counts rising edges; an accept is logged with the edge at which it happens.
    task automatic step();
        logic [1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        if (hs[0]) acc_log.push_back('{cyc + 1, 0, req_data[31:0]});
        if (hs[1]) acc_log.push_back('{cyc + 1, 1, req_data[63:32]});
        if (crc_valid && !prev_valid) rise_log.push_back(cyc);
        prev_valid = crc_valid;
        if (crc_valid && crc_ready) res_log.push_back('{cyc, crc, crc_id, crc_err});
        @(posedge clk);
        #1;
        cyc++;
        if (hs[0]) q0.delete(0);
        if (hs[1]) q1.delete(0);
        drive();
    endtask

    task automatic wait_res(input int target, input int budget, input string name);
        int b;
        b = budget;
        while (res_log.size() < target && b > 0) begin
            step();
            b--;
        end
        check(name, 32'(res_log.size()), 32'(target));
    endtask

    initial begin
        int acc0, res0, rise0, b, nacc;
        int ac[$];
        logic [31:0] exp_crc;
        res_t res;

        vecs[0] = '{0,  8, 32'h00000000, 1'b0};
        vecs[1] = '{1, 24, 32'h00000000, 1'b0};
        vecs[2] = '{0,  6, 32'h00000100, 1'b1};
        vecs[3] = '{0,  8, 32'h00000000, 1'b0};
        vecs[4] = '{1, 16, 32'hDEAD0000, 1'b0};
        vecs[5] = '{0, 13, 32'h00000007, 1'b1};

        rst       = 1'b1;
        crc_ready = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(req_ready), 32'h0);
        check("reset valid", 32'(crc_valid), 32'h0);
        check("reset crc",   crc,             32'h0);
        check("reset id",    32'(crc_id),    32'h0);
        check("reset err",   32'(crc_err),   32'h0);
        rst = 1'b0;
        step();

        // Table of frames: one frame at a time, checking tag, error flag, CRC, accept spacing and latency.
        for (int v = 0; v < 6; v++) begin
            acc0  = acc_log.size();
            res0  = res_log.size();
            rise0 = rise_log.size();
            push_frame(vecs[v].r, vecs[v].n, vecs[v].base);
            drive();
            wait_res(res0 + 1, 400, $sformatf("vec%0d timeout", v));
            res     = res_log[res0];
            exp_crc = vecs[v].exp_err ? 32'h0 : model_crc(vecs[v].base, vecs[v].n);
            check($sformatf("vec%0d id", v),  32'(res.id),  32'(vecs[v].r));
            check($sformatf("vec%0d err", v), 32'(res.err), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d crc", v), res.crc,      exp_crc);
            ac.delete();
            for (int k = acc0; k < acc_log.size(); k++) begin
                if (acc_log[k].r == vecs[v].r) ac.push_back(acc_log[k].cyc);
            end
            check($sformatf("vec%0d accepts", v), 32'(ac.size()), 32'(vecs[v].n));
            if (ac.size() == vecs[v].n) begin
                for (int i = 1; i < vecs[v].n; i++) begin
                    check($sformatf("vec%0d gap%0d", v, i), 32'(ac[i] - ac[i-1]),
                          (i % 8 == 0) ? 32'd2 : 32'd1);
                end
                if (!vecs[v].exp_err && rise_log.size() > rise0) begin
                    check($sformatf("vec%0d latency", v), 32'(rise_log[rise0] - ac[vecs[v].n - 1]), 32'd2);
                end
            end
        end

        // Output backpressure: result held for 10 cycles while requester 1 waits.
        res0 = res_log.size();
        acc0 = acc_log.size();
        crc_ready = 1'b0;
        push_frame(0, 8, 32'hA5A50000);
        drive();
        b = 20;
        while (acc_log.size() == acc0 && b > 0) begin step(); b--; end
        push_frame(1, 8, 32'h5A5A0000);
        drive();
        b = 50;
        while (!crc_valid && b > 0) begin step(); b--; end
        check("bp valid", 32'(crc_valid), 32'h1);
        exp_crc = model_crc(32'hA5A50000, 8);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp crc c%0d", k),   crc,             exp_crc);
            check($sformatf("bp id c%0d", k),    32'(crc_id),    32'h0);
            check($sformatf("bp err c%0d", k),   32'(crc_err),   32'h0);
            check($sformatf("bp ready c%0d", k), 32'(req_ready), 32'h0);
            step();
        end
        check("bp no early result", 32'(res_log.size()), 32'(res0));
        crc_ready = 1'b1;
        step();
        step();
        check("bp one handshake", 32'(res_log.size()), 32'(res0 + 1));
        check("bp result crc", res_log[res0].crc, exp_crc);
        wait_res(res0 + 2, 100, "bp req1 timeout");
        check("bp req1 id",  32'(res_log[res0 + 1].id), 32'h1);
        check("bp req1 crc", res_log[res0 + 1].crc, model_crc(32'h5A5A0000, 8));

        // Asynchronous reset in the middle of a frame.
        acc0 = acc_log.size();
        push_frame(0, 8, 32'h11110000);
        drive();
        b = 30;
        while ((acc_log.size() - acc0) < 4 && b > 0) begin step(); b--; end
        nacc = acc_log.size() - acc0;
        check("rst words before reset", 32'(nacc), 32'd4);
        rst = 1'b1;
        #2;
        check("rst ready",  32'(req_ready), 32'h0);
        check("rst valid",  32'(crc_valid), 32'h0);
        check("rst crc",    crc,             32'h0);
        check("rst id",     32'(crc_id),    32'h0);
        check("rst err",    32'(crc_err),   32'h0);
        q0.delete();
        drive();
        step();
        step();
        rst  = 1'b0;
        res0 = res_log.size();
        push_frame(1, 8, 32'h22220000);
        drive();
        wait_res(res0 + 1, 100, "post-reset timeout");
        check("post-reset id",  32'(res_log[res0].id), 32'h1);
        check("post-reset crc", res_log[res0].crc, model_crc(32'h22220000, 8));
        repeat (5) step();
        check("post-reset count", 32'(res_log.size()), 32'(res0 + 1));

        // Contention: both requesters hold valid with two frames each.
        acc0 = acc_log.size();
        res0 = res_log.size();
        push_frame(0, 8, 32'hA0000000);
        push_frame(0, 8, 32'hC0000000);
        push_frame(1, 8, 32'hB0000000);
        push_frame(1, 8, 32'hD0000000);
        drive();
        wait_res(res0 + 4, 300, "contention timeout");
        for (int f = 0; f < 4; f++) begin
            check($sformatf("cont id%0d", f), 32'(res_log[res0 + f].id), 32'(f % 2));
        end
        check("cont crc0", res_log[res0 + 0].crc, model_crc(32'hA0000000, 8));
        check("cont crc1", res_log[res0 + 1].crc, model_crc(32'hB0000000, 8));
        check("cont crc2", res_log[res0 + 2].crc, model_crc(32'hC0000000, 8));
        check("cont crc3", res_log[res0 + 3].crc, model_crc(32'hD0000000, 8));
        check("cont accepts", 32'(acc_log.size() - acc0), 32'd32);
        for (int k = 0; k < 32 && (acc0 + k) < acc_log.size(); k++) begin
            check($sformatf("cont owner w%0d", k), 32'(acc_log[acc0 + k].r), 32'((k / 8) % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
